// File: rtl/bit_capture.sv
// Serial-to-parallel capture of a single-bit stream into DATA_W-bit words,
// buffered in a 2-entry valid/ready FIFO. Optional parity: BIT_CAPTURE_PARITY_EN.
module bit_capture #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pi_bit,
  input  logic                      pi_bit_en,
  input  logic                      pi_clr,
  input  logic                      pi_ready,
  output logic [DATA_W-1:0]         po_data,
  output logic                      po_valid,
  output logic                      po_ovf,
`ifdef BIT_CAPTURE_PARITY_EN
  output logic                      po_parity,
`endif
  output logic [$clog2(DATA_W)-1:0] po_bit_cnt
);

  localparam int CW = $clog2(DATA_W);
`ifdef BIT_CAPTURE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int EW = DATA_W + PAR_W;
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic [EW-1:0]     mem_q [2];

  logic              word_done;
  logic              fifo_full;
  logic              fifo_pop;
  logic              fifo_push;
  logic              fifo_drop;
  logic [DATA_W-1:0] word_next;
  logic [EW-1:0]     entry_next;
  logic [EW-1:0]     head_entry;

  // The completed word is the shifted contents including the bit sampled now.
  always_comb begin
    if (MSB_FIRST) begin
      word_next = {shift_q[DATA_W-2:0], pi_bit};
    end else begin
      word_next = {pi_bit, shift_q[DATA_W-1:1]};
    end
  end

`ifdef BIT_CAPTURE_PARITY_EN
  assign entry_next = {^word_next, word_next};
`else
  assign entry_next = word_next;
`endif

  assign word_done = pi_bit_en && (cnt_q == LAST_CNT);
  assign fifo_full = (occ_q == 2'd2);
  assign fifo_pop  = (occ_q != 2'd0) && pi_ready;
  // A full FIFO still accepts a word when its head leaves on the same edge.
  assign fifo_push = word_done && (!fifo_full || fifo_pop);
  assign fifo_drop = word_done && fifo_full && !fifo_pop;

  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (pi_clr) begin
      shift_d  = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (pi_bit_en) begin
        shift_d = word_next;
        cnt_d   = word_done ? '0 : cnt_q + CW'(1);
      end
      if (fifo_drop) begin
        ovf_d = 1'b1;
      end
      if (fifo_push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (fifo_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (fifo_push && !fifo_pop) begin
        occ_d = occ_q + 2'd1;
      end else if (fifo_pop && !fifo_push) begin
        occ_d = occ_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!pi_clr && fifo_push) begin
      mem_q[wr_ptr_q] <= entry_next;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign po_valid   = (occ_q != 2'd0);
  // Outputs read as zero while nothing is buffered.
  assign po_data    = po_valid ? head_entry[DATA_W-1:0] : '0;
`ifdef BIT_CAPTURE_PARITY_EN
  assign po_parity  = po_valid ? head_entry[EW-1] : 1'b0;
`endif
  assign po_ovf     = ovf_q;
  assign po_bit_cnt = cnt_q;

endmodule

// File: tb/tb_bit_capture.sv
// Directed bench for bit_capture: an MSB-first and an LSB-first instance
// share one stimulus stream; expectations are hand-computed constants.
module tb_bit_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pi_bit = 1'b0;
  logic       pi_bit_en = 1'b0;
  logic       pi_clr = 1'b0;
  logic       pi_ready = 1'b0;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l;
  logic       ovf_m, ovf_l;
  logic [2:0] cnt_m, cnt_l;
`ifdef BIT_CAPTURE_PARITY_EN
  logic       par_m, par_l;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bit_capture #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .pi_bit(pi_bit), .pi_bit_en(pi_bit_en),
    .pi_clr(pi_clr), .pi_ready(pi_ready), .po_data(data_m), .po_valid(valid_m),
    .po_ovf(ovf_m),
`ifdef BIT_CAPTURE_PARITY_EN
    .po_parity(par_m),
`endif
    .po_bit_cnt(cnt_m)
  );

  bit_capture #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .pi_bit(pi_bit), .pi_bit_en(pi_bit_en),
    .pi_clr(pi_clr), .pi_ready(pi_ready), .po_data(data_l), .po_valid(valid_l),
    .po_ovf(ovf_l),
`ifdef BIT_CAPTURE_PARITY_EN
    .po_parity(par_l),
`endif
    .po_bit_cnt(cnt_l)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    pi_bit    = b;
    pi_bit_en = 1'b1;
    tick();
    pi_bit_en = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_clr();
    pi_clr = 1'b1;
    tick();
    pi_clr = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (data_m !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_m); end
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_m); end
    n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_m); end
    n_checks++; if (cnt_m !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt_m); end
    n_checks++; if (valid_l !== 1'b0) begin n_fail++; $display("FAIL reset_valid_l got=%b exp=0", valid_l); end
    tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    logic [7:0] pat;
    pat = 8'hA5;
    pi_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_bit(pat[7-i]);
      n_checks++; if (cnt_m !== 3'(i + 1)) begin n_fail++; $display("FAIL single_cnt[%0d] got=%0d exp=%0d", i, cnt_m, i + 1); end
      n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL single_early_valid[%0d] got=%b exp=0", i, valid_m); end
    end
    send_bit(pat[0]);
    n_checks++; if (valid_m !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", valid_m); end
    n_checks++; if (data_m !== 8'hA5) begin n_fail++; $display("FAIL single_data_msb got=%h exp=a5", data_m); end
    n_checks++; if (data_l !== 8'hA5) begin n_fail++; $display("FAIL single_data_lsb got=%h exp=a5", data_l); end
    n_checks++; if (cnt_m !== 3'd0) begin n_fail++; $display("FAIL single_cnt_wrap got=%0d exp=0", cnt_m); end
`ifdef BIT_CAPTURE_PARITY_EN
    n_checks++; if (par_m !== 1'b0) begin n_fail++; $display("FAIL single_parity got=%b exp=0", par_m); end
`endif
    $display("word msb=%h lsb=%h", data_m, data_l);
    tick();
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL single_valid_one_cycle got=%b exp=0", valid_m); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] pat;
    pat = 8'b1100_0000;
    pi_ready = 1'b1;
    send_word(pat);
    n_checks++; if (data_m !== 8'hC0) begin n_fail++; $display("FAIL order_msb got=%h exp=c0", data_m); end
    n_checks++; if (data_l !== 8'h03) begin n_fail++; $display("FAIL order_lsb got=%h exp=03", data_l); end
    n_checks++; if (valid_l !== 1'b1) begin n_fail++; $display("FAIL order_valid_lsb got=%b exp=1", valid_l); end
`ifdef BIT_CAPTURE_PARITY_EN
    n_checks++; if (par_l !== 1'b0) begin n_fail++; $display("FAIL order_parity got=%b exp=0", par_l); end
`endif
    $display("word msb=%h lsb=%h", data_m, data_l);
    tick();
  endtask

  task automatic test_overflow();
    do_clr();
    pi_ready = 1'b0;
    send_word(8'h01);
    n_checks++; if (data_m !== 8'h01 || valid_m !== 1'b1) begin n_fail++; $display("FAIL ovf_word1 got=%h/%b exp=01/1", data_m, valid_m); end
`ifdef BIT_CAPTURE_PARITY_EN
    n_checks++; if (par_m !== 1'b1) begin n_fail++; $display("FAIL ovf_parity got=%b exp=1", par_m); end
`endif
    send_word(8'h02);
    n_checks++; if (data_m !== 8'h01 || valid_m !== 1'b1) begin n_fail++; $display("FAIL ovf_word2_hold got=%h/%b exp=01/1", data_m, valid_m); end
    n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", ovf_m); end
    send_word(8'h03);
    n_checks++; if (ovf_m !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", ovf_m); end
    n_checks++; if (data_m !== 8'h01) begin n_fail++; $display("FAIL ovf_head got=%h exp=01", data_m); end
    $display("word msb=%h (head after overflow)", data_m);
    pi_ready = 1'b1;
    tick();
    n_checks++; if (data_m !== 8'h02 || valid_m !== 1'b1) begin n_fail++; $display("FAIL ovf_drain2 got=%h/%b exp=02/1", data_m, valid_m); end
    $display("word msb=%h", data_m);
    tick();
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL ovf_word3_lost got=%b exp=0", valid_m); end
    n_checks++; if (ovf_m !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", ovf_m); end
    do_clr();
    n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL ovf_clr got=%b exp=0", ovf_m); end
  endtask

  task automatic test_push_pop();
    logic [7:0] w3;
    w3 = 8'h03;
    do_clr();
    pi_ready = 1'b0;
    send_word(8'h01);
    send_word(8'h02);
    for (int i = 7; i >= 1; i--) send_bit(w3[i]);
    pi_ready = 1'b1;
    send_bit(w3[0]);
    n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL pp_ovf got=%b exp=0", ovf_m); end
    n_checks++; if (data_m !== 8'h02 || valid_m !== 1'b1) begin n_fail++; $display("FAIL pp_word2 got=%h/%b exp=02/1", data_m, valid_m); end
    $display("word msb=%h", data_m);
    tick();
    n_checks++; if (data_m !== 8'h03 || valid_m !== 1'b1) begin n_fail++; $display("FAIL pp_word3 got=%h/%b exp=03/1", data_m, valid_m); end
    $display("word msb=%h", data_m);
    tick();
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL pp_empty got=%b exp=0", valid_m); end
  endtask

  task automatic test_gapped();
    logic [7:0] w;
    int n_en, n_valid;
    w = 8'h5A;
    n_en = 0;
    n_valid = 0;
    do_clr();
    pi_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      pi_bit_en = (c % 2 == 0);
      pi_bit    = w[7 - c / 2];
      tick();
      if (c % 2 == 0) n_en++;
      n_checks++; if (cnt_m !== 3'(n_en % 8)) begin n_fail++; $display("FAIL gap_cnt[%0d] got=%0d exp=%0d", c, cnt_m, n_en % 8); end
      if (valid_m) begin
        n_valid++;
        n_checks++; if (data_m !== 8'h5A) begin n_fail++; $display("FAIL gap_data got=%h exp=5a", data_m); end
        $display("word msb=%h", data_m);
      end
    end
    pi_bit_en = 1'b0;
    tick();
    if (valid_m) n_valid++;
    n_checks++; if (n_valid !== 1) begin n_fail++; $display("FAIL gap_word_count got=%0d exp=1", n_valid); end
  endtask

  task automatic test_clear();
    do_clr();
    pi_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    n_checks++; if (cnt_m !== 3'd5 || ovf_m !== 1'b1) begin n_fail++; $display("FAIL clr_pre got=%0d/%b exp=5/1", cnt_m, ovf_m); end
    pi_clr    = 1'b1;
    pi_bit_en = 1'b1;
    pi_bit    = 1'b1;
    tick();
    pi_clr    = 1'b0;
    pi_bit_en = 1'b0;
    n_checks++; if (cnt_m !== 3'd0) begin n_fail++; $display("FAIL clr_cnt got=%0d exp=0", cnt_m); end
    n_checks++; if (ovf_m !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got=%b exp=0", ovf_m); end
    n_checks++; if (valid_m !== 1'b0) begin n_fail++; $display("FAIL clr_valid got=%b exp=0", valid_m); end
    pi_ready = 1'b1;
    send_word(8'h3C);
    n_checks++; if (data_m !== 8'h3C || valid_m !== 1'b1) begin n_fail++; $display("FAIL clr_clean got=%h/%b exp=3c/1", data_m, valid_m); end
    $display("word msb=%h", data_m);
    tick();
  endtask

  task automatic test_reset_mid();
    do_clr();
    pi_ready = 1'b0;
    send_word(8'hF0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    n_checks++; if (valid_m !== 1'b1 || cnt_m !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre got=%b/%0d exp=1/3", valid_m, cnt_m); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (data_m !== 8'h00 || valid_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_out got=%h/%b exp=00/0", data_m, valid_m); end
    n_checks++; if (cnt_m !== 3'd0 || ovf_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_cnt got=%0d/%b exp=0/0", cnt_m, ovf_m); end
    #1 rst_n = 1'b1;
    tick();
    pi_ready = 1'b1;
    send_word(8'h96);
    n_checks++; if (data_m !== 8'h96 || valid_m !== 1'b1) begin n_fail++; $display("FAIL rstmid_clean got=%h/%b exp=96/1", data_m, valid_m); end
    $display("word msb=%h", data_m);
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_lsb_first();
    test_overflow();
    test_push_pop();
    test_gapped();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
